mdio_reader: RTL and testbench

Clause-22 MDIO management-station read engine. Accepts a (PHY address, register address) request over a valid/ready handshake, generates MDC, serialises the read frame onto the tristate MDIO line, and returns the 16-bit register value plus a no-PHY error flag over a valid/ready response. It sits beside the MDIO write engine in the Ethernet management path; the two share the MDIO pad through the top-level tristate buffer.

---
 rtl/mdio_pkg.sv | 25 ++
 rtl/mdio_clk_gen.sv | 47 ++++
 rtl/mdio_reader.sv | 207 ++++++++++++++++++++
 tb/tb_mdio_reader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// mdio_pkg
//   Definitions shared by the Clause-22 MDIO management-station engines.
//   Contents: frame field constants (start code, read/write opcodes,
//   default preamble length) and the read-engine state type.
package mdio_pkg;

  localparam logic [1:0] MDIO_ST            = 2'b01;
  localparam logic [1:0] MDIO_OP_READ       = 2'b10;
  localparam logic [1:0] MDIO_OP_WRITE      = 2'b01;
  localparam int         MDIO_PREAMBLE_BITS = 32;

  typedef enum logic [3:0] {
    IDLE,
    PREAMBLE,
    START,
    OPCODE,
    PHY_ADDR,
    REG_ADDR,
    TA,
    DATA,
    END,
    RESPOND
  } mdio_reader_state_t;

endpackage

// File: rtl/mdio_clk_gen.sv
// mdio_clk_gen
//   Free-running MDC generator with one-cycle edge strobes. A phase counter
//   runs 0..CLKS_PER_HALF_MDC-1; at terminal count mdc toggles and, in the
//   same cycle the new mdc level appears, mdc_fall (1->0) or mdc_rise (0->1)
//   pulses for one clk.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high; mdc=0, counter=0
//   mdc       out  management clock
//   mdc_rise  out  one-cycle strobe, mdc just went 0->1
//   mdc_fall  out  one-cycle strobe, mdc just went 1->0
module mdio_clk_gen #(
  parameter int CLKS_PER_HALF_MDC = 125
) (
  input  logic clk,
  input  logic reset,
  output logic mdc,
  output logic mdc_rise,
  output logic mdc_fall
);

  localparam int PW = (CLKS_PER_HALF_MDC > 2) ? $clog2(CLKS_PER_HALF_MDC) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLKS_PER_HALF_MDC - 1);

  logic [PW-1:0] phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= '0;
      mdc      <= 1'b0;
      mdc_rise <= 1'b0;
      mdc_fall <= 1'b0;
    end else begin
      mdc_rise <= 1'b0;
      mdc_fall <= 1'b0;
      if (phase == PHASE_LAST) begin
        phase <= '0;
        mdc   <= ~mdc;
        if (mdc) mdc_fall <= 1'b1;
        else     mdc_rise <= 1'b1;
      end else begin
        phase <= phase + PW'(1);
      end
    end
  end

endmodule

// File: rtl/mdio_reader.sv
// mdio_reader
//   Clause-22 MDIO read engine. Accepts (PHY, register) address requests,
//   serialises the read frame on the tristate MDIO pad, samples turnaround
//   and data from the PHY and returns the register value with a no-PHY flag.
//   Build option: define MDIO_READER_PREAMBLE_EN to send PREAMBLE_BITS ones
//   before START; without it the frame starts directly with the start code
//   (preamble suppression).
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_phy_addr, req_reg_addr  target addresses, latched on acceptance
//   rsp_valid/rsp_ready         response handshake, rsp_valid held until taken
//   rsp_data, rsp_error         register value, TA-not-driven-low flag
//   busy                        frame in progress
//   mdio_i, mdio_o, mdio_t      pad input, output value, release (1 = high-Z)
//   mdc                         management clock
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for a request; once accepted, wait for the next MDC fall
// PREAMBLE | drive PREAMBLE_BITS ones
// START    | drive start code 01
// OPCODE   | drive read opcode 10
// PHY_ADDR | drive PHY address, MSB first
// REG_ADDR | drive register address, MSB first
// TA       | line released; second TA bit must be pulled low by the PHY
// DATA     | line released; shift in 16 data bits on MDC rises
// END      | one released idle MDC period
// RESPOND  | present response until the consumer accepts it
module mdio_reader
  import mdio_pkg::*;
#(
  parameter int CLKS_PER_HALF_MDC = 125,
  parameter int PREAMBLE_BITS     = MDIO_PREAMBLE_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_phy_addr,
  input  logic [4:0]  req_reg_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic        busy,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic        mdc
);

  if (CLKS_PER_HALF_MDC < 2) begin : g_bad_half
    $error("mdio_reader: CLKS_PER_HALF_MDC must be at least 2");
  end
  if (PREAMBLE_BITS < 1 || PREAMBLE_BITS > 32) begin : g_bad_preamble
    $error("mdio_reader: PREAMBLE_BITS must be 1..32");
  end

  logic               mdc_rise;
  logic               mdc_fall;
  mdio_reader_state_t state;
  logic [4:0]         bit_cnt;
  logic [4:0]         phy_addr;
  logic [4:0]         reg_addr;

  mdio_clk_gen #(
    .CLKS_PER_HALF_MDC(CLKS_PER_HALF_MDC)
  ) u_clk_gen (
    .clk     (clk),
    .reset   (reset),
    .mdc     (mdc),
    .mdc_rise(mdc_rise),
    .mdc_fall(mdc_fall)
  );

  // Index of the last bit in each serial field.
  function automatic logic [4:0] last_bit(input mdio_reader_state_t s);
    logic [4:0] n;
    n = 5'd0;
    case (s)
`ifdef MDIO_READER_PREAMBLE_EN
      PREAMBLE:           n = 5'(PREAMBLE_BITS - 1);
`endif
      START, OPCODE, TA:  n = 5'd1;
      PHY_ADDR, REG_ADDR: n = 5'd4;
      DATA:               n = 5'd15;
      default:            n = 5'd0;
    endcase
    return n;
  endfunction

  function automatic mdio_reader_state_t next_field(input mdio_reader_state_t s);
    mdio_reader_state_t n;
    n = RESPOND;
    case (s)
`ifdef MDIO_READER_PREAMBLE_EN
      PREAMBLE: n = START;
`endif
      START:    n = OPCODE;
      OPCODE:   n = PHY_ADDR;
      PHY_ADDR: n = REG_ADDR;
      REG_ADDR: n = TA;
      TA:       n = DATA;
      DATA:     n = END;
      default:  n = RESPOND;
    endcase
    return n;
  endfunction

  // Pad drive for bit idx of field s, as {mdio_t, mdio_o}; released bits
  // park mdio_o at 0.
  function automatic logic [1:0] drive_bit(input mdio_reader_state_t s,
                                           input logic [2:0] idx,
                                           input logic [4:0] pa,
                                           input logic [4:0] ra);
    logic [1:0] r;
    logic [4:0] pa_sh;
    logic [4:0] ra_sh;
    r     = 2'b10;
    pa_sh = pa << idx;
    ra_sh = ra << idx;
    case (s)
`ifdef MDIO_READER_PREAMBLE_EN
      PREAMBLE: r = 2'b01;
`endif
      START:    r = {1'b0, idx[0] ? MDIO_ST[0] : MDIO_ST[1]};
      OPCODE:   r = {1'b0, idx[0] ? MDIO_OP_READ[0] : MDIO_OP_READ[1]};
      PHY_ADDR: r = {1'b0, pa_sh[4]};
      REG_ADDR: r = {1'b0, ra_sh[4]};
      default:  r = 2'b10;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 5'd0;
      phy_addr  <= 5'd0;
      reg_addr  <= 5'd0;
      mdio_o    <= 1'b0;
      mdio_t    <= 1'b1;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0000;
      rsp_error <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!busy) begin
            if (req_valid && req_ready) begin
              phy_addr  <= req_phy_addr;
              reg_addr  <= req_reg_addr;
              busy      <= 1'b1;
              req_ready <= 1'b0;
              rsp_error <= 1'b0;
            end else begin
              req_ready <= 1'b1;
            end
          end else if (mdc_fall) begin
            // Every bit boundary sits on an MDC fall, so the frame starts there.
            bit_cnt <= 5'd0;
`ifdef MDIO_READER_PREAMBLE_EN
            state              <= PREAMBLE;
            {mdio_t, mdio_o}   <= drive_bit(PREAMBLE, 3'd0, phy_addr, reg_addr);
`else
            state              <= START;
            {mdio_t, mdio_o}   <= drive_bit(START, 3'd0, phy_addr, reg_addr);
`endif
          end
        end

        RESPOND: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          if (mdc_rise) begin
            if (state == TA && bit_cnt == 5'd1) rsp_error <= mdio_i;
            if (state == DATA) rsp_data <= {rsp_data[14:0], mdio_i};
          end
          if (mdc_fall) begin
            if (bit_cnt == last_bit(state)) begin
              state            <= next_field(state);
              bit_cnt          <= 5'd0;
              {mdio_t, mdio_o} <= drive_bit(next_field(state), 3'd0, phy_addr, reg_addr);
              if (state == END) begin
                rsp_valid <= 1'b1;
                busy      <= 1'b0;
              end
            end else begin
              bit_cnt          <= bit_cnt + 5'd1;
              {mdio_t, mdio_o} <= drive_bit(state, 3'(bit_cnt + 5'd1), phy_addr, reg_addr);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_reader.sv
// tb_mdio_reader
//   Directed and randomized reads against a behavioural Clause-22 PHY at
//   address 5'h0c with a pulled-up bus. Expected frames and responses are
//   derived from the frame format and the PHY register table.
module tb_mdio_reader;

  localparam int         HALF     = 4;
  localparam logic [4:0] PHY_ADDR = 5'h0c;
`ifdef MDIO_READER_PREAMBLE_EN
  localparam int PRE = 32;
`else
  localparam int PRE = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [4:0]  req_phy_addr = 5'd0;
  logic [4:0]  req_reg_addr = 5'd0;
  logic        req_ready, rsp_valid, rsp_error, busy, mdio_i, mdio_o, mdio_t, mdc;
  logic [15:0] rsp_data;

  int errors = 0;
  int checks = 0;

  logic [15:0] regs [32];

  always #5 clk = ~clk;

  mdio_reader #(
    .CLKS_PER_HALF_MDC(HALF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_phy_addr(req_phy_addr),
    .req_reg_addr(req_reg_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_error   (rsp_error),
    .busy        (busy),
    .mdio_i      (mdio_i),
    .mdio_o      (mdio_o),
    .mdio_t      (mdio_t),
    .mdc         (mdc)
  );

  // Behavioural PHY: decodes the 14 station header bits, then answers a
  // read addressed to it with TA=z,0 and 16 data bits, changing its drive
  // on MDC falling edges. The bus idles high through a pull-up.
  logic        phy_en = 1'b0;
  logic        phy_val = 1'b1;
  logic        nxt_en = 1'b0;
  logic        nxt_val = 1'b1;
  logic        phy_resp = 1'b0;
  logic [13:0] hdr = 14'd0;
  logic [15:0] phy_word = 16'd0;
  int          phy_pos = -1;
  int          phy_next;

  assign mdio_i = (mdio_t === 1'b0) ? mdio_o : (phy_en ? phy_val : 1'b1);

  always @(posedge mdc or posedge reset) begin
    if (reset) begin
      phy_pos  = -1;
      nxt_en   = 1'b0;
      nxt_val  = 1'b1;
      phy_resp = 1'b0;
    end else begin
      if (phy_pos < 0 && mdio_t === 1'b0 && mdio_o === 1'b0) begin
        phy_pos  = 0;
        hdr      = 14'd0;
        phy_resp = 1'b0;
      end
      if (phy_pos >= 0) begin
        if (phy_pos < 14) hdr = {hdr[12:0], mdio_i};
        if (phy_pos == 13) begin
          phy_resp = (hdr[13:12] == 2'b01) && (hdr[11:10] == 2'b10) && (hdr[9:5] == PHY_ADDR);
          phy_word = regs[hdr[4:0]];
        end
        phy_next = phy_pos + 1;
        if (phy_resp && phy_next == 15) begin
          nxt_en = 1'b1; nxt_val = 1'b0;
        end else if (phy_resp && phy_next >= 16 && phy_next <= 31) begin
          nxt_en = 1'b1; nxt_val = phy_word[31 - phy_next];
        end else begin
          nxt_en = 1'b0; nxt_val = 1'b1;
        end
        if (phy_pos == 31) phy_pos = -1;
        else phy_pos = phy_pos + 1;
      end
    end
  end

  always @(negedge mdc or posedge reset) begin
    if (reset) begin
      phy_en = 1'b0; phy_val = 1'b1;
    end else begin
      phy_en = nxt_en; phy_val = nxt_val;
    end
  end

  // Frame monitor: MDC periods from the first station-driven bit while busy,
  // and the station-driven bit values seen at each MDC rise.
  int   mon_rises = 0;
  bit   mon_started = 1'b0;
  logic drv_q [$];

  always @(posedge mdc) begin
    if (busy === 1'b1 && (mon_started || mdio_t === 1'b0)) begin
      mon_started = 1'b1;
      mon_rises++;
      if (mdio_t === 1'b0) drv_q.push_back(mdio_o);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [4:0] pa, input logic [4:0] ra);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("req_ready_wait", req_ready, 1'b1);
    mon_rises = 0; mon_started = 1'b0; drv_q.delete();
    req_phy_addr = pa; req_reg_addr = ra; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("accept_busy_ready", {busy, req_ready}, 2'b10);
  endtask

  task automatic do_read(input logic [4:0] pa, input logic [4:0] ra, input int hold, input bit dual);
    int          n;
    logic [63:0] exp_bits, obs_bits;
    logic [15:0] exp_data;
    logic        exp_err;
    bit          v_ok, d_ok, r_ok;
    start_req(pa, ra);
    n = 1;
    while (mdio_t === 1'b1 && n < 4 * HALF) begin @(negedge clk); n++; end
    chk("first_bit_latency", (mdio_t === 1'b0) && (n <= 2 * HALF + 1), 1'b1);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 4 * HALF * (PRE + 40)) begin
      req_valid    = 1'($urandom_range(0, 1));
      req_phy_addr = 5'($urandom);
      req_reg_addr = 5'($urandom);
      @(negedge clk); n++;
    end
    req_valid = 1'b0;
    exp_err  = (pa != PHY_ADDR);
    exp_data = exp_err ? 16'hFFFF : regs[ra];
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_error", rsp_error, exp_err);
    chk("req_ready_low_with_rsp", req_ready, 1'b0);
    chk("frame_periods", mon_rises, PRE + 33);
    exp_bits = 64'd0;
    for (int i = 0; i < PRE; i++) exp_bits = {exp_bits[62:0], 1'b1};
    exp_bits = {exp_bits[49:0], 2'b01, 2'b10, pa, ra};
    obs_bits = 64'd0;
    foreach (drv_q[i]) obs_bits = {obs_bits[62:0], drv_q[i]};
    chk("frame_len", drv_q.size(), PRE + 14);
    chk("frame_bits", obs_bits, exp_bits);
    v_ok = 1'b1; d_ok = 1'b1; r_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1) v_ok = 1'b0;
      if (rsp_data !== exp_data) d_ok = 1'b0;
      if (req_ready !== 1'b0) r_ok = 1'b0;
    end
    if (hold > 0) chk("hold_stable", {v_ok, d_ok, r_ok}, 3'b111);
    rsp_ready = 1'b1;
    if (dual) begin
      req_valid    = 1'b1;
      req_phy_addr = 5'($urandom);
      req_reg_addr = 5'($urandom);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("rsp_done", {rsp_valid, req_ready, busy}, 3'b010);
    chk("data_held_after_rsp", {rsp_data, rsp_error}, {exp_data, exp_err});
  endtask

  initial begin
    int  n;
    bit  seen;
    logic [4:0] pa, ra;
    for (int i = 0; i < 32; i++) regs[i] = 16'($urandom);
    regs[0] = 16'h1140;
    regs[1] = 16'h796D;
    regs[2] = 16'h0022;

    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_mdc", mdc, 1'b0);
    chk("reset_mdio_t", mdio_t, 1'b1);
    chk("reset_mdio_o", mdio_o, 1'b0);
    chk("reset_req_ready", req_ready, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_data", rsp_data, 16'h0000);
    chk("reset_rsp_error", rsp_error, 1'b0);
    chk("reset_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("req_ready_after_reset", req_ready, 1'b1);

    do_read(5'h0c, 5'h02, 0, 1'b0);
    do_read(5'h1f, 5'h02, 0, 1'b0);
    do_read(5'h0c, 5'h01, 100, 1'b1);

    // Abort during DATA bit 8.
    start_req(5'h0c, 5'h00);
    n = 0;
    while (mon_rises < PRE + 25 && n < 4 * HALF * (PRE + 40)) begin @(negedge clk); n++; end
    chk("reached_data_bit8", mon_rises, PRE + 25);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_state", {mdio_t, mdio_o, mdc, busy, rsp_valid, req_ready}, 6'b100000);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    chk("no_rsp_after_abort", seen, 1'b0);
    do_read(5'h0c, 5'h02, 0, 1'b0);

    do_read(5'h0c, 5'h00, 0, 1'b0);
    do_read(5'h0c, 5'h01, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      pa = ($urandom_range(0, 2) == 0) ? 5'($urandom) : PHY_ADDR;
      ra = 5'($urandom);
      do_read(pa, ra, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
